// File: rtl/riscv_pkg.sv
// Shared RV64 fetch definitions: PC width, control-flow opcodes, immediate
// extraction, prediction classes and the fetch-buffer packet.
package riscv_pkg;

    localparam int unsigned PC_W = 48;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        PK_SEQ,
        PK_JAL,
        PK_BRANCH,
        PK_RET
    } pred_kind_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } fetch_pkt_t;

    function automatic logic [PC_W-1:0] imm_j(input logic [31:0] i);
        return {{(PC_W-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [PC_W-1:0] imm_b(input logic [31:0] i);
        return {{(PC_W-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // A return is JALR that discards the link (rd=x0) and jumps through a link register.
    function automatic pred_kind_e classify(input logic [31:0] i);
        if (i[6:0] == OP_JAL)
            return PK_JAL;
        if (i[6:0] == OP_BRANCH)
            return PK_BRANCH;
        if (i[6:0] == OP_JALR && i[11:7] == 5'd0 && (i[19:15] == 5'd1 || i[19:15] == 5'd5))
            return PK_RET;
        return PK_SEQ;
    endfunction

    function automatic logic is_call(input logic [31:0] i);
        return (i[6:0] == OP_JAL || i[6:0] == OP_JALR) && (i[11:7] == 5'd1 || i[11:7] == 5'd5);
    endfunction

endpackage

// File: rtl/ifetch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Instantiated by ifetch_unit only when IFETCH_RAS_EN is defined.
module ifetch_ras
    import riscv_pkg::*;
#(
    parameter int unsigned ras_size = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            push,
    input  logic [PC_W-1:0] push_addr,
    input  logic            pop,
    output logic [PC_W-1:0] top_addr,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(ras_size);
    localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(ras_size);

    logic [PC_W-1:0]  stack_q [ras_size];
    logic [PTR_W-1:0] tos_q;
    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W:0]   depth_q;

    assign tos_inc  = tos_q + 1'b1;
    assign top_addr = stack_q[tos_q];
    assign empty    = (depth_q == '0);

    always_ff @(posedge clk) begin
        if (push)
            stack_q[tos_inc] <= push_addr;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tos_q   <= '0;
            depth_q <= '0;
        end else if (push) begin
            tos_q <= tos_inc;
            if (depth_q != DEPTH_MAX)
                depth_q <= depth_q + 1'b1;
        end else if (pop && !empty) begin
            tos_q   <= tos_q - 1'b1;
            depth_q <= depth_q - 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// RV64 instruction fetch: PC register, BHT/JAL/return predictor, 2-entry buffer to decode.
// Define IFETCH_RAS_EN to predict returns through a return-address stack.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     bht_size = 256,
    parameter int unsigned     ras_size = 8,
    parameter logic [PC_W-1:0] start_pc = '0
) (
    input  logic            clk,
    input  logic            n_reset,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            i_ready,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [PC_W-1:0] if_pred_target,
    input  logic            id_ready,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_redirect_pc,
    input  logic            ex_br_valid,
    input  logic [PC_W-1:0] ex_br_pc,
    input  logic            ex_br_taken
);

    localparam int unsigned IDX_W = $clog2(bht_size);

    fetch_pkt_t      buf_q [2];
    logic [1:0]      count_q;
    logic [1:0]      bht_q [bht_size];

    pred_kind_e      kind;
    logic [PC_W-1:0] seq_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] train_idx;
    logic            head_pop;
    logic            accept;
    fetch_pkt_t      new_pkt;
    logic            ras_empty;
    logic [PC_W-1:0] ras_top;
    logic            unused_bits;

    assign kind      = classify(instr);
    assign seq_pc    = pc + 48'd4;
    assign fetch_idx = pc[IDX_W+1:2];
    assign train_idx = ex_br_pc[IDX_W+1:2];

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = seq_pc;
        case (kind)
            PK_JAL: begin
                pred_taken  = 1'b1;
                pred_target = pc + imm_j(instr);
            end
            PK_BRANCH: begin
                if (bht_q[fetch_idx][1]) begin
                    pred_taken  = 1'b1;
                    pred_target = pc + imm_b(instr);
                end
            end
            PK_RET: begin
                if (!ras_empty) begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end
            end
            default: ;
        endcase
    end

`ifdef IFETCH_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = accept && is_call(instr);
    assign ras_pop  = accept && (kind == PK_RET) && !ras_empty;

    ifetch_ras #(
        .ras_size(ras_size)
    ) u_ras (
        .clk      (clk),
        .n_reset  (n_reset),
        .push     (ras_push),
        .push_addr(seq_pc),
        .pop      (ras_pop),
        .top_addr (ras_top),
        .empty    (ras_empty)
    );
`else
    logic [31:0] unused_ras_cfg;

    assign ras_empty      = 1'b1;
    assign ras_top        = '0;
    assign unused_ras_cfg = ras_size;
`endif

    assign if_valid       = (count_q != 2'd0);
    assign if_instr       = if_valid ? buf_q[0].instr       : '0;
    assign if_pc          = if_valid ? buf_q[0].pc          : '0;
    assign if_pred_taken  = if_valid ? buf_q[0].pred_taken  : 1'b0;
    assign if_pred_target = if_valid ? buf_q[0].pred_target : '0;

    // Redirect overrides both handshakes: nothing is consumed or accepted that cycle.
    assign head_pop = if_valid && id_ready && !ex_redirect;
    assign accept   = i_ready && (count_q != 2'd2 || head_pop) && !ex_redirect;
    assign new_pkt  = '{instr: instr, pc: pc, pred_taken: pred_taken, pred_target: pred_target};

    assign unused_bits = ^{ex_redirect_pc[1:0], ex_br_pc[PC_W-1:IDX_W+2], ex_br_pc[1:0]};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            pc <= start_pc;
        else if (ex_redirect)
            pc <= {ex_redirect_pc[PC_W-1:2], 2'b00};
        else if (accept)
            pc <= pred_target;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q  <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (ex_redirect) begin
            count_q <= '0;
        end else begin
            if (head_pop)
                buf_q[0] <= buf_q[1];
            if (accept) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && head_pop))
                    buf_q[0] <= new_pkt;
                else
                    buf_q[1] <= new_pkt;
            end
            count_q <= count_q + {1'b0, accept} - {1'b0, head_pop};
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned i = 0; i < bht_size; i++)
                bht_q[i] <= 2'b01;
        end else if (ex_br_valid) begin
            if (ex_br_taken && bht_q[train_idx] != 2'b11)
                bht_q[train_idx] <= bht_q[train_idx] + 2'b01;
            else if (!ex_br_taken && bht_q[train_idx] != 2'b00)
                bht_q[train_idx] <= bht_q[train_idx] - 2'b01;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed scenarios followed by random traffic,
// checked against a queue-based reference of fetch, prediction and buffering.
module tb_ifetch_unit;

    localparam int unsigned BHT_SIZE = 64;
    localparam int unsigned RAS_SIZE = 8;
    localparam logic [47:0] START_PC = 48'h1000;

    localparam int K_OTHER = 0;
    localparam int K_JAL   = 1;
    localparam int K_BR    = 2;
    localparam int K_JALR  = 3;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [47:0] pc;
    logic [31:0] instr;
    logic        i_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [47:0] if_pc;
    logic        if_pred_taken;
    logic [47:0] if_pred_target;
    logic        id_ready;
    logic        ex_redirect;
    logic [47:0] ex_redirect_pc;
    logic        ex_br_valid;
    logic [47:0] ex_br_pc;
    logic        ex_br_taken;

    ifetch_unit #(
        .bht_size(BHT_SIZE),
        .ras_size(RAS_SIZE),
        .start_pc(START_PC)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .pc            (pc),
        .instr         (instr),
        .i_ready       (i_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .if_pred_target(if_pred_target),
        .id_ready      (id_ready),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .ex_br_valid   (ex_br_valid),
        .ex_br_pc      (ex_br_pc),
        .ex_br_taken   (ex_br_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          rd;
        int          rs1;
        longint      imm;
        logic [31:0] raw;
    } desc_t;

    typedef struct {
        logic [31:0] instr;
        logic [47:0] pc;
        logic        taken;
        logic [47:0] target;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] ras_m[$];
    int          bht_m[BHT_SIZE];
    int          mcount;
    logic [47:0] mpc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] encode(input desc_t d);
        longint      v;
        logic [20:0] ij;
        logic [12:0] ib;
        logic [11:0] ii;
        v  = d.imm;
        ij = v[20:0];
        ib = v[12:0];
        ii = v[11:0];
        case (d.kind)
            K_JAL:   return {ij[20], ij[10:1], ij[11], ij[19:12], 5'(d.rd), 7'b1101111};
            K_BR:    return {ib[12], ib[10:5], 5'd3, 5'd2, 3'b000, ib[4:1], ib[11], 7'b1100011};
            K_JALR:  return {ii, 5'(d.rs1), 3'b000, 5'(d.rd), 7'b1100111};
            default: return d.raw;
        endcase
    endfunction

    function automatic desc_t mk(input int kind, input int rd, input int rs1, input longint imm);
        desc_t d;
        d.kind = kind;
        d.rd   = rd;
        d.rs1  = rs1;
        d.imm  = imm;
        d.raw  = 32'h0000_0013;
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        int    regs[4] = '{0, 1, 5, 7};
        d = mk($urandom_range(0, 3), regs[$urandom_range(0, 3)], regs[$urandom_range(1, 3)], 0);
        case (d.kind)
            K_JAL:   d.imm = longint'(int'($urandom_range(0, (1 << 19) - 1)) - (1 << 18)) * 2;
            K_BR:    d.imm = longint'(int'($urandom_range(0, 2047)) - 1024) * 2;
            K_JALR:  d.imm = longint'($urandom_range(0, 4095));
            default: d.raw = ($urandom() & 32'hFFFF_FF80) | 32'h13;
        endcase
        return d;
    endfunction

    // Reference prediction; also applies the call/return stack effect of an accepted fetch.
    task automatic predict(input desc_t d, input logic [47:0] fpc, output logic tk, output logic [47:0] tg);
        logic [63:0] sum;
        logic [47:0] seq;
        seq = fpc + 48'd4;
        sum = {16'b0, fpc} + d.imm;
        tk  = 1'b0;
        tg  = seq;
        if (d.kind == K_JAL) begin
            tk = 1'b1;
            tg = sum[47:0];
        end else if (d.kind == K_BR && bht_m[int'((fpc >> 2) % BHT_SIZE)] >= 2) begin
            tk = 1'b1;
            tg = sum[47:0];
        end
`ifdef IFETCH_RAS_EN
        if (d.kind == K_JALR && d.rd == 0 && (d.rs1 == 1 || d.rs1 == 5) && ras_m.size() > 0) begin
            tk = 1'b1;
            tg = ras_m.pop_back();
        end
        if ((d.kind == K_JAL || d.kind == K_JALR) && (d.rd == 1 || d.rd == 5)) begin
            ras_m.push_back(seq);
            if (ras_m.size() > RAS_SIZE)
                void'(ras_m.pop_front());
        end
`endif
    endtask

    task automatic step(input logic ir, input logic idr, input logic redir, input logic [47:0] rpc,
                        input logic brv, input logic [47:0] brpc, input logic brt, input desc_t d);
        logic        pop;
        logic        acc;
        logic        tk;
        logic [47:0] tg;
        int          idx;
        @(negedge clk);
        i_ready        = ir;
        id_ready       = idr;
        ex_redirect    = redir;
        ex_redirect_pc = rpc;
        ex_br_valid    = brv;
        ex_br_pc       = brpc;
        ex_br_taken    = brt;
        instr          = encode(d);
        #1;
        check("pc", {16'b0, pc}, {16'b0, mpc});
        check("if_valid", {63'b0, if_valid}, {63'b0, mcount > 0});
        pop = (mcount > 0) && idr && !redir;
        acc = ir && (mcount < 2 || pop) && !redir;
        if (redir) begin
            mcount = 0;
            exp_q.delete();
            mpc = {rpc[47:2], 2'b00};
        end else begin
            if (acc) begin
                predict(d, mpc, tk, tg);
                exp_q.push_back('{instr, mpc, tk, tg});
                mpc = tg;
            end
            mcount = mcount + int'(acc) - int'(pop);
        end
        if (brv) begin
            idx = int'((brpc >> 2) % BHT_SIZE);
            if (brt && bht_m[idx] < 3)
                bht_m[idx]++;
            else if (!brt && bht_m[idx] > 0)
                bht_m[idx]--;
        end
    endtask

    task automatic fetch(input desc_t d, input logic idr);
        step(1'b1, idr, 1'b0, '0, 1'b0, '0, 1'b0, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, mk(K_OTHER, 0, 0, 0));
    endtask

    task automatic redirect(input logic [47:0] rpc);
        step(1'b0, 1'b1, 1'b1, rpc, 1'b0, '0, 1'b0, mk(K_OTHER, 0, 0, 0));
    endtask

    task automatic train(input logic [47:0] brpc, input logic brt);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, brpc, brt, mk(K_OTHER, 0, 0, 0));
    endtask

    // Monitor: every head consumed by decode must match the oldest expected packet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (n_reset && if_valid && id_ready && !ex_redirect) begin
                if (exp_q.size() == 0) begin
                    check("head_unexpected", {16'b0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({if_instr, if_pc, if_pred_taken, if_pred_target} !== {e.instr, e.pc, e.taken, e.target}) begin
                        errors++;
                        $display("FAIL head: got instr=%h pc=%h taken=%b target=%h expected instr=%h pc=%h taken=%b target=%h",
                                 if_instr, if_pc, if_pred_taken, if_pred_target, e.instr, e.pc, e.taken, e.target);
                    end
                end
            end
        end
    end

    initial begin
        desc_t       nop;
        desc_t       ret;
        logic [63:0] r;
        logic [47:0] rpc;
        logic [47:0] bpc;
        nop = mk(K_OTHER, 0, 0, 0);
        ret = mk(K_JALR, 0, 1, 0);
        foreach (bht_m[i]) bht_m[i] = 1;
        mcount         = 0;
        mpc            = START_PC;
        n_reset        = 1'b0;
        i_ready        = 1'b0;
        id_ready       = 1'b0;
        ex_redirect    = 1'b0;
        ex_redirect_pc = '0;
        ex_br_valid    = 1'b0;
        ex_br_pc       = '0;
        ex_br_taken    = 1'b0;
        instr          = 32'h13;

        #12;
        check("rst_pc", {16'b0, pc}, {16'b0, START_PC});
        check("rst_if_valid", {63'b0, if_valid}, 64'd0);
        check("rst_if_instr", {32'b0, if_instr}, 64'd0);
        check("rst_if_pc", {16'b0, if_pc}, 64'd0);
        check("rst_if_pred", {15'b0, if_pred_taken, if_pred_target}, 64'd0);
        #1 n_reset = 1'b1;

        fetch(nop, 1'b1);
        check("nop_pc0", {16'b0, pc}, 64'h1000);
        fetch(nop, 1'b1);
        check("nop_pc1", {16'b0, pc}, 64'h1004);
        check("nop_ifpc0", {16'b0, if_pc}, 64'h1000);
        fetch(nop, 1'b1);
        check("nop_pc2", {16'b0, pc}, 64'h1008);
        check("nop_ifpc1", {16'b0, if_pc}, 64'h1004);

        redirect(48'h2000);
        fetch(mk(K_BR, 0, 0, 16), 1'b1);
        idle();
        check("br_nt_pc", {16'b0, pc}, 64'h2004);
        check("br_nt_pred", {63'b0, if_pred_taken}, 64'd0);
        train(48'h2000, 1'b1);
        train(48'h2000, 1'b1);
        redirect(48'h2000);
        fetch(mk(K_BR, 0, 0, 16), 1'b1);
        idle();
        check("br_t_pc", {16'b0, pc}, 64'h2010);
        check("br_t_pred", {63'b0, if_pred_taken}, 64'd1);

        redirect(48'h3000);
        fetch(mk(K_JAL, 0, 0, -8), 1'b1);
        idle();
        check("jal_pc", {16'b0, pc}, 64'h2FF8);
        check("jal_pred", {15'b0, if_pred_taken, if_pred_target}, {15'b0, 1'b1, 48'h2FF8});

        redirect(48'h6000);
        for (int i = 0; i < 4; i++) begin
            fetch(nop, 1'b0);
            if (i >= 2)
                check("stall_pc", {16'b0, pc}, 64'h6008);
        end
        idle();
        check("drain_head0", {16'b0, if_pc}, 64'h6000);
        idle();
        check("drain_head1", {16'b0, if_pc}, 64'h6004);
        idle();

        redirect(48'h7000);
        fetch(nop, 1'b0);
        fetch(nop, 1'b0);
        step(1'b1, 1'b1, 1'b1, 48'h4003, 1'b0, '0, 1'b0, nop);
        idle();
        check("redir_valid", {63'b0, if_valid}, 64'd0);
        check("redir_pc", {16'b0, pc}, 64'h4000);
        fetch(nop, 1'b1);
        idle();
        check("redir_head", {16'b0, if_pc}, 64'h4000);

        redirect(48'h5000);
        fetch(mk(K_JAL, 1, 0, 48'h1000), 1'b1);
        fetch(ret, 1'b1);
        idle();
`ifdef IFETCH_RAS_EN
        check("ret_pc", {16'b0, pc}, 64'h5004);
        check("ret_pred", {15'b0, if_pred_taken, if_pred_target}, {15'b0, 1'b1, 48'h5004});
`endif
        redirect(48'h7000);
        for (int k = 0; k < 9; k++)
            fetch(mk(K_JAL, 1, 0, 48'h100), 1'b1);
        for (int j = 0; j < 9; j++) begin
            fetch(ret, 1'b1);
            idle();
`ifdef IFETCH_RAS_EN
            if (j < 8)
                check("nest_ret", {16'b0, pc}, 64'h7804 - 64'h100 * j);
            else
                check("nest_ret_empty", {16'b0, pc}, 64'h7108);
`endif
        end

        for (int n = 0; n < 3000; n++) begin
            r   = {$urandom(), $urandom()};
            rpc = r[47:0];
            bpc = ($urandom_range(0, 1) == 1) ? mpc : {r[47:8], 8'h40};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4, rpc,
                 $urandom_range(0, 9) < 3, bpc, $urandom_range(0, 1) == 1, rand_desc());
        end

        for (int i = 0; i < 4; i++)
            idle();
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
